// File: rtl/map_probe_pkg.sv
// Shared constants and types for the map BRAM probe arbiter: requester
// indices, coordinate/address widths, map geometry, out-of-map code,
// observational FSM encoding and the (x, y) -> linear address helper.
package map_probe_pkg;

  localparam int N_REQ      = 4;
  localparam int PROBE_P1_F = 0;
  localparam int PROBE_P1_R = 1;
  localparam int PROBE_P2_F = 2;
  localparam int PROBE_P2_R = 3;

  localparam int COORD_W    = 10;
  localparam int ADDR_W     = 17;

  localparam int MAP_WIDTH  = 320;
  localparam int MAP_HEIGHT = 240;

  localparam logic [3:0] OOB_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Row-major address for a 320-wide map: y*320 + x as y*256 + y*64 + x,
  // so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {{(ADDR_W-COORD_W){1'b0}}, y};
    xw = {{(ADDR_W-COORD_W){1'b0}}, x};
    return (yw << 8) + (yw << 6) + xw;
  endfunction

endpackage

// File: rtl/map_probe_rr_arbiter.sv
// N-way round-robin picker. The search begins one position after ptr and
// wraps; the first asserted request wins. Purely combinational; the pointer
// register is owned by the parent.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan candidates ptr+1 .. ptr+N (mod N) and take the first requester
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (en && !any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map_probe_arbiter.sv
// Shares one map BRAM read port between the four collision probes.
// Round-robin grant, (x, y) -> address conversion, out-of-map bypass and a
// tag pipeline that returns each color index to its requester after
// 1+READ_LATENCY cycles, in grant order. Issue stalls while video owns
// the port; in-flight reads still complete.
// Optional statistics counters: define MAP_PROBE_STATS_EN.
module map_probe_arbiter #(
  parameter int         N_REQ        = map_probe_pkg::N_REQ,
  parameter int         MAP_WIDTH    = map_probe_pkg::MAP_WIDTH,
  parameter int         MAP_HEIGHT   = map_probe_pkg::MAP_HEIGHT,
  parameter int         READ_LATENCY = 2,
  parameter logic [3:0] OOB_CODE     = map_probe_pkg::OOB_CODE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [10*N_REQ-1:0]   req_x,
  input  logic [10*N_REQ-1:0]   req_y,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [3:0]            rsp_code,
  input  logic                  video_busy,
  output logic                  mem_en,
  output logic [16:0]           mem_addr,
  input  logic [3:0]            mem_dout
`ifdef MAP_PROBE_STATS_EN
  ,
  output logic [15:0]           stall_cnt,
  output logic [16*N_REQ-1:0]   grant_cnt
`endif
);

  import map_probe_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [N_REQ-1:0]   win_gnt;
  logic               win_any;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic               sel_oob;
  logic [ADDR_W-1:0]  sel_addr;

  state_t state;
  state_t state_next;

  logic               vld_p0;
  logic [IDX_W-1:0]   id_p0;
  logic               oob_p0;

  logic               vld_p1 [READ_LATENCY];
  logic [IDX_W-1:0]   id_p1  [READ_LATENCY];
  logic               oob_p1 [READ_LATENCY];

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req (req),
    .ptr (ptr),
    .en  (!video_busy && !rst),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign gnt = win_gnt;

  // Route the winner's coordinates through a one-hot OR mux
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_gnt[i]) begin
        sel_x = sel_x | req_x[i*COORD_W +: COORD_W];
        sel_y = sel_y | req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  assign sel_oob  = (int'(sel_x) >= MAP_WIDTH) || (int'(sel_y) >= MAP_HEIGHT);
  assign sel_addr = map_addr(sel_x, sel_y);

  // Pointer follows the last grant so the next search starts just after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= IDX_W'(N_REQ - 1);
    else if (win_any) ptr <= win_idx;
  end

  // ---- stage p0: BRAM address/enable and matching tag ----
  // Out-of-map issues keep the port idle but still carry a tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      vld_p0   <= 1'b0;
      id_p0    <= '0;
      oob_p0   <= 1'b0;
    end else begin
      mem_en <= win_any && !sel_oob;
      vld_p0 <= win_any;
      if (win_any) begin
        mem_addr <= sel_addr;
        id_p0    <= win_idx;
        oob_p0   <= sel_oob;
      end
    end
  end

  // ---- stage p1: tag delay line matching the BRAM read latency ----
  // Drains regardless of video_busy; reset discards everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        vld_p1[k] <= 1'b0;
        id_p1[k]  <= '0;
        oob_p1[k] <= 1'b0;
      end
    end else begin
      vld_p1[0] <= vld_p0;
      id_p1[0]  <= id_p0;
      oob_p1[0] <= oob_p0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_p1[k] <= vld_p1[k-1];
        id_p1[k]  <= id_p1[k-1];
        oob_p1[k] <= oob_p1[k-1];
      end
    end
  end

  // Response decode: data lines up with the last tag stage
  always_comb begin
    rsp_valid = '0;
    rsp_code  = '0;
    if (vld_p1[READ_LATENCY-1]) begin
      rsp_valid[id_p1[READ_LATENCY-1]] = 1'b1;
      rsp_code = oob_p1[READ_LATENCY-1] ? OOB_CODE : mem_dout;
    end
  end

  // Observational FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Classify each cycle from request presence and port ownership;
  // an illegal encoding falls back to IDLE
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE, ST_ISSUE, ST_STALL: begin
        if (req != '0) state_next = video_busy ? ST_STALL : ST_ISSUE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef MAP_PROBE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic lost_now;
  assign lost_now = win_any && ((req & ~win_gnt) != '0);

  // Saturating stall/lost-arbitration and per-requester grant counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      grant_cnt <= '0;
    end else begin
      if (state_next == ST_STALL || lost_now) stall_cnt <= sat_inc(stall_cnt);
      for (int i = 0; i < N_REQ; i++) begin
        if (win_gnt[i]) grant_cnt[16*i +: 16] <= sat_inc(grant_cnt[16*i +: 16]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_map_probe_arbiter.sv
// Self-checking bench for map_probe_arbiter: address/OOB vector table,
// round-robin, video stall, mid-flight reset and randomized traffic
// against a cycle-indexed scoreboard. Stats checks when MAP_PROBE_STATS_EN.
module tb_map_probe_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] req_x;
  logic [39:0] req_y;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_code;
  logic        video_busy;
  logic        mem_en;
  logic [16:0] mem_addr;
  logic [3:0]  mem_dout;
`ifdef MAP_PROBE_STATS_EN
  logic [15:0] stall_cnt;
  logic [63:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  map_probe_arbiter #(.READ_LATENCY(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_code   (rsp_code),
    .video_busy (video_busy),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout)
`ifdef MAP_PROBE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .grant_cnt  (grant_cnt)
`endif
  );

  // Map contents: a fixed scramble of the address
  function automatic logic [3:0] color(input int a);
    return 4'((a ^ (a >> 4) ^ (a >> 9)) & 15);
  endfunction

  // Two-cycle synchronous BRAM model
  logic [3:0] pipe0 = 4'h0;
  logic [3:0] pipe1 = 4'h0;
  always @(posedge clk) begin
    pipe1 <= pipe0;
    pipe0 <= mem_en ? color(int'(mem_addr)) : 4'h0;
  end
  assign mem_dout = pipe1;

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic [3:0] r_req;
  int         rx [4];
  int         ry [4];
  bit         vb;

  // Reference model state
  int         m_ptr;
  bit         m_en;
  int         m_addr;
  bit         ev    [16];
  int         eid   [16];
  logic [3:0] ecode [16];
  int         cyc_n;
  int         last_g;
  int         last_gnt_act;

  typedef struct {
    int         id;
    int         x;
    int         y;
    bit         exp_en;
    int         exp_addr;
    logic [3:0] exp_code;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic drive();
    req = r_req;
    video_busy = vb;
    for (int i = 0; i < 4; i++) begin
      req_x[10*i +: 10] = 10'(rx[i]);
      req_y[10*i +: 10] = 10'(ry[i]);
    end
  endtask

  task automatic model_clear();
    m_ptr = 3;
    m_en  = 1'b0;
    m_addr = 0;
    cyc_n = 0;
    for (int s = 0; s < 16; s++) ev[s] = 1'b0;
  endtask

  // One clock cycle: compare against the model, then advance the model
  task automatic cyc();
    int eg;
    int j;
    int slot;
    int s;
    int a;
    bit oob;
    drive();
    @(negedge clk);
    eg = -1;
    if (!vb) begin
      for (int k = 1; k <= 4; k++) begin
        j = (m_ptr + k) % 4;
        if (eg < 0 && r_req[j]) eg = j;
      end
    end
    last_g = eg;
    last_gnt_act = int'(gnt);
    chk("gnt", int'(gnt), (eg >= 0) ? (1 << eg) : 0);
    chk("mem_en", int'(mem_en), int'(m_en));
    if (m_en) chk("mem_addr", int'(mem_addr), m_addr);
    slot = cyc_n % 16;
    chk("rsp_valid", int'(rsp_valid), ev[slot] ? (1 << eid[slot]) : 0);
    if (ev[slot]) chk("rsp_code", int'(rsp_code), int'(ecode[slot]));
    ev[slot] = 1'b0;
    @(posedge clk);
    if (eg >= 0) begin
      oob = (rx[eg] >= 320) || (ry[eg] >= 240);
      a = ry[eg] * 320 + rx[eg];
      m_ptr = eg;
      m_en = !oob;
      m_addr = a;
      s = (cyc_n + 1 + RL) % 16;
      ev[s] = 1'b1;
      eid[s] = eg;
      ecode[s] = oob ? 4'hF : color(a);
    end else begin
      m_en = 1'b0;
    end
    cyc_n++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    r_req = 4'b0;
    vb = 1'b0;
    drive();
    model_clear();
    @(negedge clk);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_code", int'(rsp_code), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{0, 10,   2,    1'b1, 650,   4'h0};
    tbl[1] = '{2, 319,  239,  1'b1, 76799, 4'h0};
    tbl[2] = '{2, 320,  5,    1'b0, 0,     4'h0};
    tbl[3] = '{1, 0,    240,  1'b0, 0,     4'h0};
    tbl[4] = '{3, 0,    0,    1'b1, 0,     4'h0};
    tbl[5] = '{1, 319,  0,    1'b1, 319,   4'h0};
    tbl[6] = '{3, 0,    239,  1'b1, 76480, 4'h0};
    tbl[7] = '{0, 1023, 1023, 1'b0, 0,     4'h0};
    tbl[8] = '{2, 5,    1,    1'b1, 325,   4'h0};
    for (int i = 0; i < 9; i++)
      tbl[i].exp_code = tbl[i].exp_en ? color(tbl[i].exp_addr) : 4'hF;

    for (int i = 0; i < 4; i++) begin
      rx[i] = 0;
      ry[i] = 0;
    end
    do_reset();

    // Address / out-of-map table, one isolated request per entry
    for (int v = 0; v < 9; v++) begin
      r_req = 4'b0;
      r_req[tbl[v].id] = 1'b1;
      rx[tbl[v].id] = tbl[v].x;
      ry[tbl[v].id] = tbl[v].y;
      drive();
      @(negedge clk);
      chk("tbl_gnt", int'(gnt), 1 << tbl[v].id);
      @(posedge clk);
      #1;
      r_req = 4'b0;
      drive();
      @(negedge clk);
      chk("tbl_mem_en", int'(mem_en), int'(tbl[v].exp_en));
      if (tbl[v].exp_en) chk("tbl_mem_addr", int'(mem_addr), tbl[v].exp_addr);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_rsp_early", int'(rsp_valid), 0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_rsp_valid", int'(rsp_valid), 1 << tbl[v].id);
      chk("tbl_rsp_code", int'(rsp_code), int'(tbl[v].exp_code));
      @(posedge clk);
      #1;
    end

    // All four requesting: strict rotation 0,1,2,3,0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx[i] = $urandom_range(0, 319);
      ry[i] = $urandom_range(0, 239);
    end
    r_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_seq", last_gnt_act, 1 << (k % 4));
    end
    r_req = 4'b0;
    for (int k = 0; k < 4; k++) cyc();

    // Video stall with a response in flight
    r_req = 4'b0001;
    cyc();
    r_req = 4'b0110;
    vb = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_no_gnt", last_gnt_act, 0);
    end
    vb = 1'b0;
    cyc();
    chk("after_stall_1", last_gnt_act, 4'b0010);
    r_req[1] = 1'b0;
    cyc();
    chk("after_stall_2", last_gnt_act, 4'b0100);
    r_req = 4'b0;
    for (int k = 0; k < 4; k++) cyc();

    // Reset one cycle after granting requester 3
    r_req = 4'b1000;
    cyc();
    chk("pre_rst_gnt3", last_gnt_act, 4'b1000);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("post_rst_quiet", int'(rsp_valid), 0);
    end
    r_req = 4'b1111;
    cyc();
    chk("first_after_rst", last_gnt_act, 4'b0001);
    r_req = 4'b0;
    for (int k = 0; k < 4; k++) cyc();

    // Randomized traffic with handshake-respecting requesters
    do_reset();
    for (int n = 0; n < 400; n++) begin
      vb = ($urandom_range(0, 4) == 0);
      cyc();
      if (last_g >= 0) r_req[last_g] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          r_req[i] = 1'b1;
          rx[i] = $urandom_range(0, 340);
          ry[i] = $urandom_range(0, 255);
        end
      end
    end
    r_req = 4'b0;
    vb = 1'b0;
    for (int k = 0; k < 4; k++) cyc();

`ifdef MAP_PROBE_STATS_EN
    // 10 stall cycles plus 3 lost-arbitration cycles
    do_reset();
    r_req = 4'b0001;
    vb = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    vb = 1'b0;
    r_req = 4'b1111;
    for (int k = 0; k < 3; k++) cyc();
    r_req = 4'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("stall_cnt", int'(stall_cnt), 13);
    chk("grant_cnt0", int'(grant_cnt[15:0]), 1);
    chk("grant_cnt1", int'(grant_cnt[31:16]), 1);
    chk("grant_cnt2", int'(grant_cnt[47:32]), 1);
    chk("grant_cnt3", int'(grant_cnt[63:48]), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
